// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, sign fixup in a final cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state;
  logic [4:0]         cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               sign_q;
  logic               sign_r;
  logic               b_zero;

  logic               accept;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != StIdle);

  always_comb begin
    accept   = (state == StIdle) && start && !mthi && !mtlo;
    a_mag_in = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag_in = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_mag};
    if (rem_sh >= {1'b0, b_mag}) begin
      div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    prod_fix = (op_q[0] && sign_q) ? -acc : acc;
    quo_fix  = (op_q[0] && sign_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (op_q[0] && sign_r) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_mag       <= '0;
      acc         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      b_zero      <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (mthi) hi <= src_a;
          if (mtlo) lo <= src_a;
          if (accept) begin
            state       <= StRun;
            cnt         <= 5'd31;
            op_q        <= op;
            a_q         <= src_a;
            b_mag       <= b_mag_in;
            acc         <= {{WIDTH{1'b0}}, a_mag_in};
            sign_q      <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            sign_r      <= op[0] & src_a[WIDTH-1];
            b_zero      <= (src_b == '0);
            div_by_zero <= 1'b0;
          end
        end
        StRun: begin
          acc <= op_q[1] ? div_next : mul_next;
          if (cnt == 5'd0) begin
            state <= StFix;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        StFix: begin
          state <= StIdle;
          done  <= 1'b1;
          if (op_q[1]) begin
            if (b_zero) begin
              hi          <= a_q;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences and random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      2'd1: begin
        p = sa * sb;
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'd2) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom);
  endtask

  // Entered at the negedge following the start edge; returns at the negedge where done is seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input logic ed, input bit timing);
    int cyc;
    int bcnt;
    issue(o, a, b);
    wait_done(cyc, bcnt);
    check({name, "_done"}, done, 1);
    if (timing) begin
      check({name, "_latency"}, cyc, 33);
      check({name, "_busy_cycles"}, bcnt, 33);
      check({name, "_busy_at_done"}, busy, 0);
    end
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_dbz"}, div_by_zero, ed);
  endtask

  initial begin
    int cyc;
    int bcnt;
    logic [64:0] m;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{"multu_max",  2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{"mult_neg3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{"mult_minsq", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0};
    vecs[3] = '{"div_neg7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{"divu_7_2",   2'd2, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0};
    vecs[5] = '{"div_ovf",    2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    vecs[6] = '{"div_zero",   2'd3, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{"divu_zero",  2'd2, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1};

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0;
    src_a = 32'h0; src_b = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    check("reset_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].dbz, 1'b1);
    end

    // div_by_zero holds in idle, then the next accepted start clears it
    repeat (3) @(negedge clk);
    check("dbz_hold", div_by_zero, 1);
    issue(2'd0, 32'd3, 32'd5);
    check("dbz_cleared", div_by_zero, 0);
    wait_done(cyc, bcnt);
    check("after_dbz_lo", lo, 15);

    // MTHI / MTLO in idle
    @(negedge clk);
    mthi = 1'b1; src_a = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", hi, 32'h1234);
    mtlo = 1'b1; src_a = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", lo, 32'h5678);

    // start/mthi/mtlo during RUN are ignored; HI/LO hold throughout
    issue(2'd1, 32'd5, 32'hFFFF_FFFE);
    repeat (4) @(negedge clk);
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'd0; src_a = 32'hDEAD_BEEF; src_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("run_hold_hilo", {hi, lo}, {32'h1234, 32'h5678});
    check("run_busy", busy, 1);
    wait_done(cyc, bcnt);
    check("run_ignore_hi", hi, 32'hFFFF_FFFF);
    check("run_ignore_lo", lo, 32'hFFFF_FFF6);
    @(negedge clk);
    check("no_extra_start", busy, 0);

    // start together with mtlo in idle: only LO written
    start = 1'b1; mtlo = 1'b1; src_a = 32'hAAAA_5555; op = 2'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("start_mtlo_lo", lo, 32'hAAAA_5555);
    check("start_mtlo_hi", hi, 32'hFFFF_FFFF);
    check("start_mtlo_busy", busy, 0);

    // asynchronous reset mid-RUN
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_check("after_rst", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);

    // random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      m = model(ro, ra, rb);
      run_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0], m[64],
                (i % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
